// File: rtl/sonar_pkg.sv
// HC-SR04 emulator shared definitions: state codes and default timing
// constants for a 50 MHz system clock.
`timescale 1ns/1ps
package sonar_pkg;

   localparam int unsigned CLK_HZ = 50_000_000;

   localparam int unsigned TRIG_MIN_CYCLES_DEF = 500;
   localparam int unsigned BURST_CYCLES_DEF    = 10_000;
   localparam int unsigned CYCLES_PER_CM_DEF   = 2_941;
   localparam int unsigned MAX_CM_DEF          = 400;
   localparam int unsigned TIMEOUT_CYCLES_DEF  = 1_900_000;
   localparam int unsigned HOLDOFF_CYCLES_DEF  = 500_000;

   localparam int unsigned CNT_W = 22;

   typedef enum logic [3:0] {
      OCIOSO    = 4'b0000,
      MEDE_TRIG = 4'b0001,
      BURST     = 4'b0010,
      ECO       = 4'b0011,
      HOLDOFF   = 4'b0100
   } estado_t;

endpackage

// File: rtl/sincronizador_borda.sv
// Two-flop synchronizer for an asynchronous input, with one-cycle
// rise and fall pulses derived from the synchronized level.
`timescale 1ns/1ps
module sincronizador_borda (
   input  logic clock,
   input  logic reset,
   input  logic d_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync_o = sync_q;
   assign rise_o = sync_q & ~prev_q;
   assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/hcsr04_sensor_emulator.sv
// HC-SR04 responder: measures the trigger pulse and answers with an echo
// whose width encodes the distance latched at the end of the trigger.
`timescale 1ns/1ps
module hcsr04_sensor_emulator
   import sonar_pkg::*;
#(
   parameter int unsigned TRIG_MIN_CYCLES = TRIG_MIN_CYCLES_DEF,
   parameter int unsigned BURST_CYCLES    = BURST_CYCLES_DEF,
   parameter int unsigned CYCLES_PER_CM   = CYCLES_PER_CM_DEF,
   parameter int unsigned MAX_CM          = MAX_CM_DEF,
   parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF,
   parameter int unsigned HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       trigger,
   input  logic [8:0] distancia_cm,
   input  logic       objeto,
   output logic       echo,
   output logic       ocupado,
   output logic       trigger_invalido,
   output logic [3:0] db_estado
);

   localparam logic [CNT_W-1:0] TRIG_MIN = CNT_W'(TRIG_MIN_CYCLES);
   localparam logic [CNT_W-1:0] BURST_LST = CNT_W'(BURST_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LST = CNT_W'(HOLDOFF_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CPCM = CNT_W'(CYCLES_PER_CM);
   localparam logic [8:0] MAXD = 9'(MAX_CM);

   logic trig_s;
   logic trig_rise;
   logic trig_fall;

   estado_t          estado_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] larg_q;
   logic [CNT_W-1:0] larg_d;
   logic [8:0]       dist_ef;
   logic             echo_q;
   logic             inv_q;
   logic [3:0]       db_d;

   sincronizador_borda u_sinc (
      .clock  (clock),
      .reset  (reset),
      .d_i    (trigger),
      .sync_o (trig_s),
      .rise_o (trig_rise),
      .fall_o (trig_fall)
   );

   // Sensor cannot report closer than 2 cm
   always_comb begin
      dist_ef = (distancia_cm < 9'd2) ? 9'd2 : distancia_cm;
      larg_d = CNT_W'(dist_ef) * CPCM;
      if (!objeto || (distancia_cm > MAXD)) larg_d = TIMEOUT;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q <= OCIOSO;
         cnt_q    <= '0;
         larg_q   <= '0;
         echo_q   <= 1'b0;
         inv_q    <= 1'b0;
      end else begin
         inv_q <= 1'b0;
         case (estado_q)
            OCIOSO: begin
               if (trig_rise) begin
                  estado_q <= MEDE_TRIG;
                  cnt_q    <= CNT_W'(1);
               end
            end
            MEDE_TRIG: begin
               if (trig_fall) begin
                  cnt_q <= '0;
                  if (cnt_q >= TRIG_MIN) begin
                     larg_q   <= larg_d;
                     estado_q <= BURST;
                  end else begin
                     inv_q    <= 1'b1;
                     estado_q <= OCIOSO;
                  end
               end else if (trig_s && (cnt_q < TRIG_MIN)) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            BURST: begin
               if (cnt_q == BURST_LST) begin
                  cnt_q    <= '0;
                  echo_q   <= 1'b1;
                  estado_q <= ECO;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ECO: begin
               if (cnt_q == (larg_q - 1'b1)) begin
                  cnt_q    <= '0;
                  echo_q   <= 1'b0;
                  estado_q <= HOLDOFF;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            HOLDOFF: begin
               if (cnt_q == HOLD_LST) begin
                  cnt_q    <= '0;
                  estado_q <= OCIOSO;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               cnt_q    <= '0;
               echo_q   <= 1'b0;
               estado_q <= OCIOSO;
            end
         endcase
      end
   end

   always_comb begin
      db_d = 4'b1110;
      case (estado_q)
         OCIOSO, MEDE_TRIG, BURST, ECO, HOLDOFF: db_d = estado_q;
         default: db_d = 4'b1110;
      endcase
   end

   assign echo             = echo_q;
   assign trigger_invalido = inv_q;
   assign ocupado          = (estado_q != OCIOSO);
   assign db_estado        = db_d;

endmodule

// File: tb/tb_hcsr04_sensor_emulator.sv
// Randomized self-checking bench for the HC-SR04 emulator against a
// pulse-level reference model of the trigger/echo protocol.
`timescale 1ns/1ps
module tb_hcsr04_sensor_emulator;

   localparam int TMIN = 5;
   localparam int BURST = 20;
   localparam int CPCM = 3;
   localparam int MAXCM = 400;
   localparam int TOUT = 2000;
   localparam int HOLD = 50;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       trigger = 1'b0;
   logic [8:0] distancia_cm = '0;
   logic       objeto = 1'b0;
   logic       echo;
   logic       ocupado;
   logic       trigger_invalido;
   logic [3:0] db_estado;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int   rise_q[$];
   int   width_q[$];
   int   st_q[$];
   int   inv_n = 0;
   int   ocup_err = 0;
   int   hi_cnt = 0;
   bit   echo_p = 1'b0;
   logic [3:0] db_p = '0;

   hcsr04_sensor_emulator #(
      .TRIG_MIN_CYCLES (TMIN),
      .BURST_CYCLES    (BURST),
      .CYCLES_PER_CM   (CPCM),
      .MAX_CM          (MAXCM),
      .TIMEOUT_CYCLES  (TOUT),
      .HOLDOFF_CYCLES  (HOLD)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .trigger          (trigger),
      .distancia_cm     (distancia_cm),
      .objeto           (objeto),
      .echo             (echo),
      .ocupado          (ocupado),
      .trigger_invalido (trigger_invalido),
      .db_estado        (db_estado)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (echo && !echo_p) rise_q.push_back(cyc);
      if (echo) hi_cnt++;
      if (!echo && echo_p) begin
         width_q.push_back(hi_cnt);
         hi_cnt = 0;
      end
      if (trigger_invalido) inv_n++;
      if (db_estado != db_p) st_q.push_back(int'(db_estado));
      if (ocupado != (db_estado != 4'd0)) ocup_err++;
      echo_p = echo;
      db_p = db_estado;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", tag, obs, exp);
      end
   endtask

   function automatic int wexp(input int d, input bit o);
      if (!o || d > MAXCM) return TOUT;
      if (d < 2) return 2 * CPCM;
      return d * CPCM;
   endfunction

   task automatic clr();
      rise_q.delete();
      width_q.delete();
      st_q.delete();
      inv_n = 0;
      ocup_err = 0;
      hi_cnt = 0;
   endtask

   task automatic wait_until(input int x);
      while (cyc < x) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic pulse(input int n, output int l);
      @(posedge clock);
      #1 trigger = 1'b1;
      repeat (n) @(posedge clock);
      #1 trigger = 1'b0;
      l = cyc;
   endtask

   task automatic trial(input string nm, input int n, input int d,
                        input bit o, input bit chg);
      int  l;
      int  w;
      bit  ok;
      ok = (n >= TMIN);
      w = wexp(d, o);
      clr();
      #1 distancia_cm = 9'(d);
      objeto = o;
      pulse(n, l);
      if (chg) begin
         wait_until(l + 10);
         distancia_cm = 9'd50;
         objeto = ~o;
      end
      wait_until(l + (ok ? BURST + 3 + w + HOLD + 10 : 10));
      chk({nm, "_inv"}, inv_n, ok ? 0 : 1);
      chk({nm, "_necho"}, rise_q.size(), ok ? 1 : 0);
      if (ok && rise_q.size() > 0)
         chk({nm, "_rise"}, rise_q[0] - l, BURST + 3);
      if (ok && width_q.size() > 0)
         chk({nm, "_width"}, width_q[0], w);
      chk({nm, "_ocup"}, ocup_err, 0);
      chk({nm, "_idle"}, int'(db_estado), 0);
   endtask

   initial begin
      int l;
      int seq1[5] = '{1, 2, 3, 4, 0};
      int seq2[2] = '{1, 0};

      repeat (3) @(posedge clock);
      #1;
      chk("rst_echo", int'(echo), 0);
      chk("rst_ocup", int'(ocupado), 0);
      chk("rst_inv", int'(trigger_invalido), 0);
      chk("rst_db", int'(db_estado), 0);
      reset = 1'b1;
      repeat (3) @(posedge clock);

      trial("nom", 10, 100, 1'b1, 1'b0);
      chk("nom_nst", st_q.size(), 5);
      for (int i = 0; i < 5 && i < st_q.size(); i++)
         chk("nom_st", st_q[i], seq1[i]);

      trial("short", 3, 100, 1'b1, 1'b0);
      chk("short_nst", st_q.size(), 2);
      for (int i = 0; i < 2 && i < st_q.size(); i++)
         chk("short_st", st_q[i], seq2[i]);

      trial("noobj", 8, 100, 1'b0, 1'b0);
      trial("range", 8, 450, 1'b1, 1'b0);
      trial("edge400", 5, 400, 1'b1, 1'b0);
      trial("clamp", 7, 0, 1'b1, 1'b1);
      trial("one", 6, 1, 1'b1, 1'b0);

      clr();
      #1 distancia_cm = 9'd100;
      objeto = 1'b1;
      pulse(10, l);
      wait_until(l + 100);
      begin
         int l2;
         pulse(10, l2);
      end
      wait_until(l + 340);
      begin
         int l3;
         pulse(8, l3);
      end
      wait_until(l + BURST + 3 + 300 + HOLD + 10);
      chk("busy_necho", rise_q.size(), 1);
      chk("busy_inv", inv_n, 0);
      if (rise_q.size() > 0) chk("busy_rise", rise_q[0] - l, BURST + 3);
      if (width_q.size() > 0) chk("busy_width", width_q[0], 300);
      trial("after", 9, 37, 1'b1, 1'b0);

      clr();
      #1 distancia_cm = 9'd100;
      pulse(10, l);
      wait_until(l + 100);
      chk("pre_rst_echo", int'(echo), 1);
      #2 reset = 1'b0;
      #1;
      chk("arst_echo", int'(echo), 0);
      chk("arst_db", int'(db_estado), 0);
      chk("arst_ocup", int'(ocupado), 0);
      @(posedge clock);
      #1 reset = 1'b1;
      repeat (3) @(posedge clock);
      trial("post_rst", 6, 250, 1'b1, 1'b0);

      for (int k = 0; k < 8; k++) begin
         int n;
         int d;
         bit o;
         n = int'($urandom_range(2, 12));
         d = int'($urandom_range(0, 511));
         o = ($urandom_range(0, 3) != 0);
         trial("rnd", n, d, o, 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
